// File: rtl/ce_pwm.sv
// CE-paced PWM with double-buffered duty and period-end strobe; optional dead-time pair via PWM_DEADTIME_EN.
// Latency: PWM_OUT is registered one CLK behind CNT; PERIOD_END pulses the CLK after the wrap edge.
// Backpressure: none; the counter advances only on CE ticks while EN is high.
module ce_pwm #(
    parameter int WIDTH  = 8,
    parameter int PERIOD = 255
`ifdef PWM_DEADTIME_EN
    , parameter int DEAD = 2
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             EN,
    input  logic [WIDTH:0]   DUTY,
    input  logic             LOAD,
    output logic [WIDTH-1:0] CNT,
    output logic             PWM_OUT,
    output logic             PERIOD_END
`ifdef PWM_DEADTIME_EN
    , output logic           PWM_N
`endif
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(PERIOD);
    localparam logic [WIDTH:0]   FULL = (WIDTH+1)'(PERIOD + 1);

    logic [WIDTH:0] shadow;
    logic [WIDTH:0] active;
    logic [WIDTH:0] next_duty;
    logic [WIDTH:0] eff_duty;
    logic           raw;

    // A LOAD coinciding with a transfer hands the fresh DUTY straight to the new period.
    always_comb begin
        next_duty = LOAD ? DUTY : shadow;
        eff_duty  = (active > FULL) ? FULL : active;
        raw       = ({1'b0, CNT} < eff_duty);
    end

`ifdef PWM_DEADTIME_EN
    localparam logic [WIDTH-1:0] DEAD_TICKS = WIDTH'(DEAD);

    logic             raw_q;
    logic [WIDTH-1:0] dcnt;
    logic [WIDTH-1:0] dcnt_nxt;
    logic             dead_done;

    // Every edge of raw restarts the guard interval; it drains on CE ticks only.
    always_comb begin
        if (raw != raw_q) begin
            dcnt_nxt = DEAD_TICKS;
        end else if (CE && (dcnt != '0)) begin
            dcnt_nxt = dcnt - 1'b1;
        end else begin
            dcnt_nxt = dcnt;
        end
        dead_done = (dcnt_nxt == '0);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT        <= '0;
            shadow     <= '0;
            active     <= '0;
            PWM_OUT    <= 1'b0;
            PERIOD_END <= 1'b0;
`ifdef PWM_DEADTIME_EN
            PWM_N      <= 1'b0;
            raw_q      <= 1'b0;
            dcnt       <= '0;
`endif
        end else begin
            if (LOAD) begin
                shadow <= DUTY;
            end

            if (!EN) begin
                CNT        <= '0;
                active     <= next_duty;
                PERIOD_END <= 1'b0;
            end else if (CE) begin
                if (CNT == TERM) begin
                    CNT        <= '0;
                    active     <= next_duty;
                    PERIOD_END <= 1'b1;
                end else begin
                    CNT        <= CNT + 1'b1;
                    PERIOD_END <= 1'b0;
                end
            end else begin
                PERIOD_END <= 1'b0;
            end

`ifdef PWM_DEADTIME_EN
            raw_q   <= raw;
            dcnt    <= dcnt_nxt;
            PWM_OUT <= EN & raw & dead_done;
            PWM_N   <= EN & ~raw & dead_done;
`else
            PWM_OUT <= EN & raw;
`endif
        end
    end

endmodule
